// File: rtl/dense_output_writer.sv
// -----------------------------------------------------------------------------
// dense_output_writer
//
// Write-back end of the dense layer. Walks the 32-bit pre-activation
// accumulators of acc_vector in index order, requantises each one to int8 and
// writes one result per cycle into tensor RAM at base_addr + k.
//
// Requantisation of accumulator a with multiplier M, shift S, zero point ZP:
//   p = a * M                                  (signed 64-bit product)
//   r = (p + 2^(30+S)) >>> (31+S)              (round half up, arithmetic)
//   v = r + ZP
//   result = clamp(v, relu_en ? ZP : -128, 127)
//
// Pipeline (one index per cycle, never stalls):
//   issue : s1 <= acc_vector[k]
//   mult  : s2 <= s1 * M
//   write : round/shift/bias/clamp, register din/waddr/we
// With start sampled in cycle 0, index k is issued in cycle 1+k and its write
// is visible in cycle 4+k. done pulses in cycle 4+N (cycle 1 when N == 0).
//
// Handshake: start is a level sampled only in IDLE; the job parameters and
// base_addr are latched when it is accepted, while acc_vector is read live
// and must be held stable for as long as busy is high. tensor_ram_we is a
// one-cycle write strobe qualifying tensor_ram_waddr/tensor_ram_din; the RAM
// cannot apply back-pressure.
//
// Ports:
//   clk              clock
//   reset            synchronous, active-high reset; aborts a run at once
//   start            begin write-back (ignored unless IDLE)
//   output_size      number of results N (values above MAX_OUT act as MAX_OUT)
//   acc_vector       signed 32-bit accumulators, MAX_OUT entries
//   requant_mult     signed Q31 multiplier M
//   requant_shift    extra right shift S (0..31)
//   out_zero_point   signed int8 output zero point ZP
//   relu_en          1: lower clamp bound is ZP instead of -128
//   base_addr        tensor RAM address of result 0
//   tensor_ram_waddr write address (base_addr + k, wraps)
//   tensor_ram_we    write enable, one result per asserted cycle
//   tensor_ram_din   int8 result
//   busy             high from the cycle after start up to and including done
//   done             one-cycle pulse after the last write
// -----------------------------------------------------------------------------
module dense_output_writer #(
   parameter int MAX_OUT = 64,
   parameter int ADDR_W  = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [6:0]                output_size,
   input  logic [MAX_OUT-1:0][31:0]  acc_vector,
   input  logic signed [31:0]        requant_mult,
   input  logic [4:0]                requant_shift,
   input  logic signed [7:0]         out_zero_point,
   input  logic                      relu_en,
   input  logic [ADDR_W-1:0]         base_addr,
   output logic [ADDR_W-1:0]         tensor_ram_waddr,
   output logic                      tensor_ram_we,
   output logic [7:0]                tensor_ram_din,
   output logic                      busy,
   output logic                      done
);

   localparam int CNT_W = 7;
   localparam int IDX_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_OUT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   // Control decoded from the state
   logic accept;
   logic issue;

   // Latched job parameters
   logic [CNT_W-1:0]    n_q;
   logic signed [31:0]  mult_q;
   logic [4:0]          shift_q;
   logic signed [7:0]   zp_q;
   logic                relu_q;
   logic [ADDR_W-1:0]   base_q;

   // Issue index
   logic [CNT_W-1:0]    idx_q;

   // Pipeline stage 1 (accumulator) and stage 2 (product)
   logic                v1_q;
   logic signed [31:0]  s1_q;
   logic [CNT_W-1:0]    k1_q;
   logic                v2_q;
   logic signed [63:0]  s2_q;
   logic [CNT_W-1:0]    k2_q;

   // Write-stage combinational datapath
   logic [5:0]          round_pos;
   logic signed [63:0]  round_sum;
   logic signed [63:0]  rounded;
   logic signed [63:0]  biased;
   logic signed [63:0]  lo_bound;
   logic signed [63:0]  clamped;

   logic [CNT_W-1:0]    n_in;
   logic [CNT_W-1:0]    last_idx;

   assign n_in     = (output_size > MAX_N) ? MAX_N : output_size;
   assign last_idx = n_q - CNT_W'(1);

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state and control decode
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      issue      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = (n_in == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            issue = 1'b1;
            if (idx_q == last_idx) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // The write register is the last stage; once both earlier stages
            // are empty the final write is on the bus this cycle.
            if (!v1_q && !v2_q) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

   // ---------------------------------------------------------------------------
   // Parameter latch and issue counter
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         n_q     <= '0;
         mult_q  <= '0;
         shift_q <= '0;
         zp_q    <= '0;
         relu_q  <= 1'b0;
         base_q  <= '0;
         idx_q   <= '0;
      end else begin
         if (accept) begin
            n_q     <= n_in;
            mult_q  <= requant_mult;
            shift_q <= requant_shift;
            zp_q    <= out_zero_point;
            relu_q  <= relu_en;
            base_q  <= base_addr;
            idx_q   <= '0;
         end else if (issue) begin
            idx_q <= idx_q + CNT_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stages 1 and 2: accumulator fetch and Q31 multiply
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         v1_q <= 1'b0;
         s1_q <= '0;
         k1_q <= '0;
         v2_q <= 1'b0;
         s2_q <= '0;
         k2_q <= '0;
      end else begin
         v1_q <= issue;
         if (issue) begin
            s1_q <= acc_vector[idx_q[IDX_W-1:0]];
            k1_q <= idx_q;
         end
         v2_q <= v1_q;
         if (v1_q) begin
            s2_q <= 64'(s1_q) * 64'(mult_q);
            k2_q <= k1_q;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Write stage: rounding shift, zero-point add, clamp
   // ---------------------------------------------------------------------------
   always_comb begin
      // Bit position of the rounding half; the shift is one position further.
      // Maximum is 61, so the sum below cannot overflow a signed 64-bit value
      // (|s2| <= 2^62).
      round_pos = 6'd30 + {1'b0, shift_q};
      round_sum = s2_q + (64'sd1 <<< round_pos);
      rounded   = round_sum >>> (round_pos + 6'd1);
      biased    = rounded + 64'(zp_q);
      lo_bound  = relu_q ? 64'(zp_q) : -64'sd128;
      if (biased > 64'sd127) begin
         clamped = 64'sd127;
      end else if (biased < lo_bound) begin
         clamped = lo_bound;
      end else begin
         clamped = biased;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tensor_ram_we    <= 1'b0;
         tensor_ram_din   <= '0;
         tensor_ram_waddr <= '0;
      end else begin
         tensor_ram_we <= v2_q;
         if (v2_q) begin
            tensor_ram_din   <= clamped[7:0];
            // Address arithmetic is modulo the RAM size.
            tensor_ram_waddr <= base_q + ADDR_W'(k2_q);
         end
      end
   end

endmodule

// File: tb/tb_dense_output_writer.sv
// -----------------------------------------------------------------------------
// tb_dense_output_writer
//
// Directed and randomized write-back jobs against a reference model that
// evaluates the requantisation rules with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_dense_output_writer;

   logic                  clk;
   logic                  reset;
   logic                  start;
   logic [6:0]            output_size;
   logic [63:0][31:0]     acc_vec;
   logic signed [31:0]    requant_mult;
   logic [4:0]            requant_shift;
   logic signed [7:0]     out_zero_point;
   logic                  relu_en;
   logic [7:0]            base_addr;
   logic [7:0]            tensor_ram_waddr;
   logic                  tensor_ram_we;
   logic [7:0]            tensor_ram_din;
   logic                  busy;
   logic                  done;

   int checks = 0;
   int errors = 0;

   // Scoreboard: expected results, and what the last job wrote
   logic [7:0] exp_q[$];
   logic [7:0] exp_addr_q[$];
   int         wr_cyc_q[$];
   logic [7:0] wr_addr_q[$];
   logic [7:0] wr_din_q[$];

   dense_output_writer #(.MAX_OUT(64), .ADDR_W(8)) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .output_size      (output_size),
      .acc_vector       (acc_vec),
      .requant_mult     (requant_mult),
      .requant_shift    (requant_shift),
      .out_zero_point   (out_zero_point),
      .relu_en          (relu_en),
      .base_addr        (base_addr),
      .tensor_ram_waddr (tensor_ram_waddr),
      .tensor_ram_we    (tensor_ram_we),
      .tensor_ram_din   (tensor_ram_din),
      .busy             (busy),
      .done             (done)
   );

   // ---------------------------------------------------------------------------
   // Clock
   // ---------------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Check helper
   // ---------------------------------------------------------------------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: round(a*M / 2^(31+S)) half up, + ZP, clamp
   // ---------------------------------------------------------------------------
   function automatic logic [7:0] model(input logic signed [31:0] acc,
                                        input logic signed [31:0] m,
                                        input int s,
                                        input logic signed [7:0] zp,
                                        input bit relu);
      longint p;
      longint d;
      longint num;
      longint q;
      longint v;
      longint lo;
      p   = longint'(acc) * longint'(m);
      d   = longint'(1) << (31 + s);
      num = p + d / 2;
      q   = num / d;
      // floor division for negative numerators
      if ((num % d) != 0 && num < 0) q = q - 1;
      v  = q + longint'(zp);
      lo = relu ? longint'(zp) : -128;
      if (v > 127) v = 127;
      if (v < lo) v = lo;
      return v[7:0];
   endfunction

   function automatic logic [7:0] logged_din(input int k);
      return (k < wr_din_q.size()) ? wr_din_q[k] : 8'hxx;
   endfunction

   function automatic logic [7:0] logged_addr(input int k);
      return (k < wr_addr_q.size()) ? wr_addr_q[k] : 8'hxx;
   endfunction

   // ---------------------------------------------------------------------------
   // Driver + monitor for one job. Cycle numbers are relative to the cycle in
   // which start is presented (cycle 0). Outputs are sampled on the negedge.
   // ---------------------------------------------------------------------------
   task automatic run_job(input int n, input logic [31:0] m, input logic [4:0] s,
                          input logic [7:0] zp, input bit relu, input logic [7:0] base,
                          input bit extra_start, input string name);
      int n_eff;
      int busy_cnt;
      int done_cnt;
      int done_cyc;
      int exp_done;
      int budget;
      n_eff    = (n > 64) ? 64 : n;
      busy_cnt = 0;
      done_cnt = 0;
      done_cyc = -1;
      exp_done = (n_eff == 0) ? 1 : 4 + n_eff;
      budget   = n_eff + 12;
      exp_q.delete();
      exp_addr_q.delete();
      wr_cyc_q.delete();
      wr_addr_q.delete();
      wr_din_q.delete();
      for (int k = 0; k < n_eff; k++) begin
         exp_q.push_back(model(acc_vec[k], m, int'(s), zp, relu));
         exp_addr_q.push_back(8'(int'(base) + k));
      end

      @(negedge clk);
      start          = 1'b1;
      output_size    = 7'(n);
      requant_mult   = m;
      requant_shift  = s;
      out_zero_point = zp;
      relu_en        = relu;
      base_addr      = base;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         start = (extra_start && i == 3) ? 1'b1 : 1'b0;
         if (tensor_ram_we) begin
            wr_cyc_q.push_back(i);
            wr_addr_q.push_back(tensor_ram_waddr);
            wr_din_q.push_back(tensor_ram_din);
         end
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_cyc = i;
         end
         if (done_cnt > 0 && i >= done_cyc + 2) break;
      end
      start = 1'b0;

      check({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
      check({name, "_done_cyc"}, 64'(done_cyc), 64'(exp_done));
      check({name, "_busy_cnt"}, 64'(busy_cnt), 64'(exp_done));
      check({name, "_wr_cnt"}, 64'(wr_din_q.size()), 64'(n_eff));
      for (int k = 0; k < n_eff && k < wr_din_q.size(); k++) begin
         logic [7:0] e_din;
         logic [7:0] e_addr;
         e_din  = exp_q.pop_front();
         e_addr = exp_addr_q.pop_front();
         check($sformatf("%s_w%0d_cyc", name, k), 64'(wr_cyc_q[k]), 64'(4 + k));
         check($sformatf("%s_w%0d_addr", name, k), 64'(wr_addr_q[k]), 64'(e_addr));
         check($sformatf("%s_w%0d_din", name, k), 64'(wr_din_q[k]), 64'(e_din));
      end
   endtask

   task automatic rand_acc(input int mode);
      for (int k = 0; k < 64; k++) begin
         if (mode == 0) acc_vec[k] = 32'($urandom_range(0, 4000)) - 32'd2000;
         else           acc_vec[k] = $urandom;
      end
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int stray;
      reset          = 1'b1;
      start          = 1'b0;
      output_size    = '0;
      acc_vec        = '0;
      requant_mult   = '0;
      requant_shift  = '0;
      out_zero_point = '0;
      relu_en        = 1'b0;
      base_addr      = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_we",    64'(tensor_ram_we),    64'd0);
      check("rst_waddr", 64'(tensor_ram_waddr), 64'd0);
      check("rst_din",   64'(tensor_ram_din),   64'd0);
      check("rst_busy",  64'(busy),             64'd0);
      check("rst_done",  64'(done),             64'd0);
      reset = 1'b0;

      // Single result: 1000 * 0.5 = 500 saturates to 127
      acc_vec    = '0;
      acc_vec[0] = 32'd1000;
      run_job(1, 32'h4000_0000, 5'd0, 8'd0, 1'b0, 8'd10, 1'b0, "t1");
      check("t1_const_din",  64'(logged_din(0)),  64'd127);
      check("t1_const_addr", 64'(logged_addr(0)), 64'd10);

      // Rounding half up with M = 0.5
      acc_vec[0] = 32'd3;
      acc_vec[1] = -32'sd3;
      acc_vec[2] = 32'd1;
      run_job(3, 32'h4000_0000, 5'd0, 8'd0, 1'b0, 8'd50, 1'b0, "t2");
      check("t2_const_p3", 64'(logged_din(0)), 64'h02);
      check("t2_const_m3", 64'(logged_din(1)), 64'hFF);
      check("t2_const_p1", 64'(logged_din(2)), 64'h01);

      // Saturation
      acc_vec[0] = 32'd1000000;
      acc_vec[1] = -32'sd1000000;
      run_job(2, 32'h7FFF_FFFF, 5'd0, 8'd0, 1'b0, 8'd0, 1'b0, "t3");
      check("t3_const_hi", 64'(logged_din(0)), 64'h7F);
      check("t3_const_lo", 64'(logged_din(1)), 64'h80);
      acc_vec[0] = -32'sd1000000;
      run_job(1, 32'h7FFF_FFFF, 5'd0, 8'hFB, 1'b1, 8'd0, 1'b0, "t3r");
      check("t3r_const", 64'(logged_din(0)), 64'hFB);

      // Full vector with address wrap
      for (int k = 0; k < 64; k++) acc_vec[k] = 32'(k << 1);
      run_job(64, 32'h4000_0000, 5'd0, 8'd0, 1'b0, 8'd200, 1'b0, "t4");
      check("t4_addr55", 64'(logged_addr(55)), 64'd255);
      check("t4_addr56", 64'(logged_addr(56)), 64'd0);
      check("t4_din63",  64'(logged_din(63)),  64'd63);

      // Empty job, and start re-asserted while running
      run_job(0, 32'h4000_0000, 5'd0, 8'd0, 1'b0, 8'd5, 1'b0, "t5z");
      rand_acc(0);
      run_job(20, 32'h5555_5555, 5'd2, 8'd3, 1'b0, 8'd30, 1'b1, "t5s");

      // Oversized output_size behaves as 64
      rand_acc(0);
      run_job(100, 32'h6000_0000, 5'd4, 8'hF0, 1'b1, 8'd128, 1'b0, "t7");

      // Reset in cycle 10 of a full run
      rand_acc(0);
      @(negedge clk);
      start          = 1'b1;
      output_size    = 7'd64;
      requant_mult   = 32'h4000_0000;
      requant_shift  = 5'd0;
      out_zero_point = 8'd0;
      relu_en        = 1'b0;
      base_addr      = 8'd0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (i == 10) reset = 1'b1;
      end
      @(negedge clk);
      check("t6_we",   64'(tensor_ram_we), 64'd0);
      check("t6_busy", 64'(busy),          64'd0);
      check("t6_done", 64'(done),          64'd0);
      reset = 1'b0;
      stray = 0;
      repeat (6) begin
         @(negedge clk);
         if (tensor_ram_we || busy || done) stray++;
      end
      check("t6_quiet", 64'(stray), 64'd0);
      run_job(8, 32'h2000_0000, 5'd1, 8'd7, 1'b0, 8'd90, 1'b0, "t6n");

      // Randomized jobs
      for (int j = 0; j < 10; j++) begin
         rand_acc(j % 3 == 2 ? 1 : 0);
         run_job(int'($urandom_range(0, 70)), $urandom, 5'($urandom_range(0, 10)),
                 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
                 $sformatf("rnd%0d", j));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
